// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit feeding the register file write port.
// Latency: WIDTH+1 cycles from accepted start to done (1 cycle for divide by zero).
// Backpressure: one op in flight; start is ignored while busy; flush aborts RUN/DONE with no write-back.
//
// Ports: clk/rst (async active-low), start/flush/op/sign_en/src1/src2/rd_in requests;
//        busy, done, we_out (== done), rd_out, result (held until the next completion).
// Optional: define MULDIV_SIGNED_EN to honour sign_en (two's complement operands).

`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif

module mul_div_unit #(
    parameter int WIDTH = `DATA_LEN,
    parameter int CNT_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     flush,
    input  logic [1:0]               op,
    input  logic                     sign_en,
    input  logic [WIDTH-1:0]         src1,
    input  logic [WIDTH-1:0]         src2,
    input  logic [`REG_ADDR_LEN-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic                     we_out,
    output logic [`REG_ADDR_LEN-1:0] rd_out,
    output logic [WIDTH-1:0]         result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]         acc_q, acc_d;      // MUL: product; DIV: remainder:quotient
    logic [WIDTH-1:0]           a_q, a_d;          // |multiplicand| or |divisor|
    logic [WIDTH-1:0]           b_q, b_d;          // |multiplier| (shifts right) or |dividend| (shifts left)
    logic [1:0]                 op_q, op_d;
    logic [`REG_ADDR_LEN-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]           res_q, res_d;

    logic                       s1_neg, s2_neg;
    logic [WIDTH-1:0]           mag1, mag2;
    logic [WIDTH:0]             mul_sum;
    logic [WIDTH:0]             div_sh;
    logic [WIDTH+1:0]           div_diff;
    logic [2*WIDTH-1:0]         prod;
    logic [WIDTH-1:0]           quo, rem;

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_d;     // product / quotient sign
    logic rneg_q, rneg_d;   // remainder sign follows the dividend
    assign s1_neg = sign_en & src1[WIDTH-1];
    assign s2_neg = sign_en & src2[WIDTH-1];
    assign mag1   = s1_neg ? (~src1 + 1'b1) : src1;
    assign mag2   = s2_neg ? (~src2 + 1'b1) : src2;
`else
    logic unused_sign_en;
    assign unused_sign_en = sign_en;
    assign s1_neg = 1'b0;
    assign s2_neg = 1'b0;
    assign mag1   = src1;
    assign mag2   = src2;
`endif

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], b_q[WIDTH-1]};
    // MSB set means the trial subtraction borrowed.
    assign div_diff = {1'b0, div_sh} - {2'b00, a_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        res_d   = res_q;
        prod    = '0;
        quo     = '0;
        rem     = '0;
`ifdef MULDIV_SIGNED_EN
        neg_d   = neg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d  = op;
                    rd_d  = rd_in;
                    a_d   = mag2;
                    b_d   = mag1;
                    acc_d = '0;
                    cnt_d = '0;
`ifdef MULDIV_SIGNED_EN
                    neg_d  = s1_neg ^ s2_neg;
                    rneg_d = s1_neg;
`endif
                    if (op[1] && (src2 == '0)) begin
                        // Divide by zero: all-ones quotient, raw dividend as remainder.
                        state_d = S_DONE;
                        res_d   = op[0] ? src1 : '1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!op_q[1]) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                        b_d   = b_q >> 1;
                    end else begin
                        b_d = b_q << 1;
                        if (!div_diff[WIDTH+1])
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = S_DONE;
                        prod    = acc_d;
                        quo     = acc_d[WIDTH-1:0];
                        rem     = acc_d[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
                        if (neg_q)  prod = ~acc_d + 1'b1;
                        if (neg_q)  quo  = ~acc_d[WIDTH-1:0] + 1'b1;
                        if (rneg_q) rem  = ~acc_d[2*WIDTH-1:WIDTH] + 1'b1;
`endif
                        case (op_q)
                            2'b00:   res_d = prod[WIDTH-1:0];
                            2'b01:   res_d = prod[2*WIDTH-1:WIDTH];
                            2'b10:   res_d = quo;
                            default: res_d = rem;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;   // S_DONE lasts one cycle, flushed or not
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE) && !flush;
    assign we_out = done;
    assign rd_out = rd_q;
    assign result = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, sign_en;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic [4:0]  rd_in;
    logic        busy, done, we_out;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .sign_en(sign_en), .src1(src1), .src2(src2), .rd_in(rd_in),
        .busy(busy), .done(done), .we_out(we_out), .rd_out(rd_out), .result(result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until done is seen at a falling edge (bounded).
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic s,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b; rd_in = r; sign_en = s;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, seen);
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp));
        check({tag, "_rd_out"}, 64'(rd_out), 64'(r));
        check({tag, "_we_out"}, 64'(we_out), 64'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        int done_cnt;
        rst = 1'b0; start = 1'b0; flush = 1'b0; sign_en = 1'b0;
        op = 2'b00; src1 = '0; src2 = '0; rd_in = '0;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(we_out), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Multiply and high half
        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 5'd7, 1'b0, 32'd15, 32);
        run_op("mulh_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b0, 32'hFFFFFFFE, 32);
        run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h00000001, 32);

        // Divide / remainder, including divide by zero
        run_op("div_100_7", 2'b10, 32'd100, 32'd7, 5'd12, 1'b0, 32'd14, 32);
        run_op("rem_100_7", 2'b11, 32'd100, 32'd7, 5'd13, 1'b0, 32'd2, 32);
        run_op("div_by0", 2'b10, 32'h1234, 32'd0, 5'd4, 1'b0, 32'hFFFFFFFF, 0);
        run_op("rem_by0", 2'b11, 32'h1234, 32'd0, 5'd5, 1'b0, 32'h00001234, 0);

        // A second start during RUN must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd6; src2 = 32'd7; rd_in = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b10; src1 = 32'd9; src2 = 32'd3; rd_in = 5'd9;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_in_run", 64'(busy), 64'd1);
        wait_done(lat, seen);
        check("busy_ign_seen", 64'(seen), 64'd1);
        check("busy_ign_lat", 64'(lat), 64'd28);
        check("busy_ign_result", 64'(result), 64'd42);
        check("busy_ign_rd", 64'(rd_out), 64'd3);
        @(negedge clk);
        check("busy_ign_idle", 64'(busy), 64'd0);

        // flush during RUN: no write-back, result retained
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd2; rd_in = 5'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_result", 64'(result), 64'd42);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush_no_done", 64'(done_cnt), 64'd0);

        // flush wins over start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; src1 = 32'd1; src2 = 32'd1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_over_start", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9; rd_in = 5'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("arst_no_done", 64'(done_cnt), 64'd0);
        run_op("post_rst_mul", 2'b00, 32'd3, 32'd5, 5'd7, 1'b0, 32'd15, 32);

        // Signed vectors: results depend on whether signed support is built in
`ifdef MULDIV_SIGNED_EN
        run_op("sdiv_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b1, 32'hFFFFFFFD, 32);
        run_op("srem_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b1, 32'hFFFFFFFF, 32);
        run_op("sdiv_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h80000000, 32);
        run_op("srem_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h00000000, 32);
        run_op("smulh_m3x4", 2'b01, 32'hFFFFFFFD, 32'd4, 5'd9, 1'b1, 32'hFFFFFFFF, 32);
`else
        run_op("udiv_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b1, 32'h7FFFFFFC, 32);
        run_op("urem_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b1, 32'h00000001, 32);
        run_op("udiv_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h00000000, 32);
        run_op("urem_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h80000000, 32);
        run_op("umulh_m3x4", 2'b01, 32'hFFFFFFFD, 32'd4, 5'd9, 1'b1, 32'h00000003, 32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
